// File: rtl/wb_regfile_if.sv
// Bus between decode/issue, EX write-back and the write-back register file.
// The master modport is the decode/EX side; the slave modport is the register file.
interface wb_regfile_if #(
    parameter int NREG = 16,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    logic            wb_en_i;
    logic [AW-1:0]   wb_addr_i;
    logic [DW-1:0]   wb_data_i;
    logic            flush_i;
    logic            issue_v_i;
    logic            issue_wb_i;
    logic [AW-1:0]   rd_sel_i;
    logic [AW-1:0]   rs_sel_i;
    logic            rs_use_i;
    logic [DW-1:0]   rd_value_o;
    logic [DW-1:0]   rs_value_o;
    logic            hazard_o;
    logic [NREG-1:0] pending_o;

    modport master (
        output wb_en_i, wb_addr_i, wb_data_i, flush_i,
        output issue_v_i, issue_wb_i, rd_sel_i, rs_sel_i, rs_use_i,
        input  rd_value_o, rs_value_o, hazard_o, pending_o
    );

    modport slave (
        input  wb_en_i, wb_addr_i, wb_data_i, flush_i,
        input  issue_v_i, issue_wb_i, rd_sel_i, rs_sel_i, rs_use_i,
        output rd_value_o, rs_value_o, hazard_o, pending_o
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back register file with same-cycle write bypass and a per-register
// pending scoreboard that stalls issue until in-flight results return.
module wb_regfile #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_pending;
    logic            r_last_valid;
    logic [AW-1:0]   r_last_addr;

    logic [NREG-1:0] w_wb_hit;
    logic [NREG-1:0] w_pend_eff;
    logic [NREG-1:0] w_pend_next;
    logic            w_hazard;
    logic            w_fire;
    logic [DW-1:0]   w_rd_value;
    logic [DW-1:0]   w_rs_value;

    always_comb begin
        w_wb_hit = '0;
        if (bus.wb_en_i) begin
            w_wb_hit[bus.wb_addr_i] = 1'b1;
        end
    end

    // A write-back landing this cycle resolves its hazard immediately.
    assign w_pend_eff = r_pending & ~w_wb_hit;

    always_comb begin
        w_hazard = 1'b0;
        if (!rst && bus.issue_v_i) begin
            w_hazard = w_pend_eff[bus.rd_sel_i] |
                       (bus.rs_use_i & w_pend_eff[bus.rs_sel_i]);
        end
    end

    assign w_fire = bus.issue_v_i & ~w_hazard & ~bus.flush_i;

    // Ordering of the three updates gives set > flush > clear per bit.
    always_comb begin
        w_pend_next = r_pending & ~w_wb_hit;
        if (bus.flush_i && r_last_valid) begin
            w_pend_next[r_last_addr] = 1'b0;
        end
        if (w_fire && bus.issue_wb_i) begin
            w_pend_next[bus.rd_sel_i] = 1'b1;
        end
    end

    always_comb begin
        w_rd_value = r_regs[bus.rd_sel_i];
        if (bus.wb_en_i && (bus.wb_addr_i == bus.rd_sel_i)) begin
            w_rd_value = bus.wb_data_i;
        end
    end

    always_comb begin
        w_rs_value = r_regs[bus.rs_sel_i];
        if (bus.wb_en_i && (bus.wb_addr_i == bus.rs_sel_i)) begin
            w_rs_value = bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wb_en_i) begin
            r_regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            r_pending    <= w_pend_next;
            r_last_valid <= w_fire & bus.issue_wb_i;
            r_last_addr  <= bus.rd_sel_i;
        end
    end

    assign bus.rd_value_o = w_rd_value;
    assign bus.rs_value_o = w_rs_value;
    assign bus.hazard_o   = w_hazard;
    assign bus.pending_o  = r_pending;
endmodule

// File: tb/tb_wb_regfile.sv
// Scenario bench for wb_regfile: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_wb_regfile;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] sb [$];
    logic [31:0] exp_v;
    logic [31:0] m_regs [16];

    wb_regfile_if #(.NREG(16), .DW(32)) bus ();

    wb_regfile #(.NREG(16), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.wb_en_i    = 1'b0;
        bus.wb_addr_i  = '0;
        bus.wb_data_i  = '0;
        bus.flush_i    = 1'b0;
        bus.issue_v_i  = 1'b0;
        bus.issue_wb_i = 1'b0;
        bus.rd_sel_i   = '0;
        bus.rs_sel_i   = '0;
        bus.rs_use_i   = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] rd, input logic [3:0] rs,
                               input logic use_rs, input logic wb);
        bus.issue_v_i  = 1'b1;
        bus.issue_wb_i = wb;
        bus.rd_sel_i   = rd;
        bus.rs_sel_i   = rs;
        bus.rs_use_i   = use_rs;
    endtask

    task automatic drive_wb(input logic [3:0] addr, input logic [31:0] data);
        bus.wb_en_i   = 1'b1;
        bus.wb_addr_i = addr;
        bus.wb_data_i = data;
        m_regs[addr]  = data;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        sb.push_back(32'h0);
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL reset_pending_async got=%h exp=%h", bus.pending_o, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 32'h0;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.rd_sel_i = 4'(i);
            bus.rs_sel_i = 4'(15 - i);
            bus.issue_v_i = 1'b1;
            bus.rs_use_i = 1'b1;
            bus.issue_wb_i = 1'b0;
            sb.push_back(m_regs[i]);
            sb.push_back(m_regs[15 - i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (bus.rd_value_o !== exp_v) begin
                errors++;
                $display("FAIL reset_rd[%0d] got=%h exp=%h", i, bus.rd_value_o, exp_v);
            end
            exp_v = sb.pop_front();
            checks++;
            if (bus.rs_value_o !== exp_v) begin
                errors++;
                $display("FAIL reset_rs[%0d] got=%h exp=%h", 15 - i, bus.rs_value_o, exp_v);
            end
            checks++;
            if (bus.hazard_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hazard[%0d] got=%b exp=0", i, bus.hazard_o);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.pending_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pending got=%h exp=0000", bus.pending_o);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        drive_idle();
        drive_wb(4'd5, 32'hDEAD_BEEF);
        bus.rs_sel_i = 4'd5;
        bus.rd_sel_i = 4'd0;
        sb.push_back(32'hDEAD_BEEF);
        sb.push_back(32'h0);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (bus.rs_value_o !== exp_v) begin
            errors++;
            $display("FAIL bypass_rs got=%h exp=%h", bus.rs_value_o, exp_v);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_value_o !== exp_v) begin
            errors++;
            $display("FAIL bypass_rd_other got=%h exp=%h", bus.rd_value_o, exp_v);
        end
        // Distinct patterns into more registers, including register 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            drive_wb(4'(i * 4), 32'h1111_0000 ^ (32'(i) * 32'h0101_0101) ^ 32'h8000_0001);
        end
        @(negedge clk);
        drive_idle();
        bus.rd_sel_i = 4'd5;
        bus.rs_sel_i = 4'd5;
        sb.push_back(m_regs[5]);
        sb.push_back(m_regs[5]);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_value_o !== exp_v) begin
            errors++;
            $display("FAIL stored_rd5 got=%h exp=%h", bus.rd_value_o, exp_v);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rs_value_o !== exp_v) begin
            errors++;
            $display("FAIL stored_rs5 got=%h exp=%h", bus.rs_value_o, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            bus.rd_sel_i = 4'(i * 4);
            bus.rs_sel_i = 4'(i * 4 + 1);
            sb.push_back(m_regs[i * 4]);
            sb.push_back(m_regs[i * 4 + 1]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (bus.rd_value_o !== exp_v) begin
                errors++;
                $display("FAIL stored_rd[%0d] got=%h exp=%h", i * 4, bus.rd_value_o, exp_v);
            end
            exp_v = sb.pop_front();
            checks++;
            if (bus.rs_value_o !== exp_v) begin
                errors++;
                $display("FAIL stored_rs[%0d] got=%h exp=%h", i * 4 + 1, bus.rs_value_o, exp_v);
            end
        end
    endtask

    task automatic test_raw_hazard();
        @(negedge clk);
        drive_idle();
        drive_issue(4'd3, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        drive_issue(4'd6, 4'd3, 1'b1, 1'b1);
        sb.push_back(32'h0000_0008);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL raw_pending_set got=%h exp=%h", bus.pending_o, exp_v);
        end
        checks++;
        if (bus.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL raw_hazard got=%b exp=1", bus.hazard_o);
        end
        @(negedge clk);
        drive_wb(4'd3, 32'hA5A5_5A5A);
        sb.push_back(32'hA5A5_5A5A);
        #1;
        checks++;
        if (bus.pending_o !== 16'h0008) begin
            errors++;
            $display("FAIL raw_stall_holds got=%h exp=0008", bus.pending_o);
        end
        checks++;
        if (bus.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_wb_resolves got=%b exp=0", bus.hazard_o);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rs_value_o !== exp_v) begin
            errors++;
            $display("FAIL raw_bypass_rs got=%h exp=%h", bus.rs_value_o, exp_v);
        end
        @(negedge clk);
        drive_idle();
        drive_issue(4'd3, 4'd0, 1'b0, 1'b1);
        sb.push_back(32'h0000_0040);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL raw_fired_pending got=%h exp=%h", bus.pending_o, exp_v);
        end
        @(negedge clk);
        drive_idle();
        drive_issue(4'd4, 4'd3, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.pending_o !== 16'h0048) begin
            errors++;
            $display("FAIL immf_pending got=%h exp=0048", bus.pending_o);
        end
        checks++;
        if (bus.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL immf_ignores_rs got=%b exp=0", bus.hazard_o);
        end
        bus.rs_use_i = 1'b1;
        #1;
        checks++;
        if (bus.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL rs_used_hazard got=%b exp=1", bus.hazard_o);
        end
        drive_issue(4'd6, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (bus.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_hazard got=%b exp=1", bus.hazard_o);
        end
        bus.issue_v_i = 1'b0;
        #1;
        checks++;
        if (bus.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL hazard_needs_valid got=%b exp=0", bus.hazard_o);
        end
        @(negedge clk);
        drive_idle();
        drive_wb(4'd3, 32'h0000_0303);
        @(negedge clk);
        drive_idle();
        drive_wb(4'd6, 32'h0000_0606);
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.pending_o !== 16'h0000) begin
            errors++;
            $display("FAIL raw_cleanup got=%h exp=0000", bus.pending_o);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_idle();
        drive_issue(4'd7, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        sb.push_back(32'h0000_0080);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL flush_pre got=%h exp=%h", bus.pending_o, exp_v);
        end
        bus.flush_i = 1'b1;
        drive_issue(4'd9, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        sb.push_back(32'h0);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL flush_kill got=%h exp=%h", bus.pending_o, exp_v);
        end
        drive_issue(4'd7, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        bus.flush_i = 1'b1;
        drive_wb(4'd7, 32'h0000_0707);
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.pending_o !== 16'h0000) begin
            errors++;
            $display("FAIL flush_with_wb got=%h exp=0000", bus.pending_o);
        end
        drive_issue(4'd10, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        drive_issue(4'd11, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive_idle();
        bus.flush_i = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.pending_o !== 16'h0400) begin
            errors++;
            $display("FAIL flush_last_nowb got=%h exp=0400", bus.pending_o);
        end
        drive_wb(4'd10, 32'h0000_0A0A);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_idle();
        drive_issue(4'd2, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        drive_wb(4'd2, 32'h2222_0002);
        drive_issue(4'd2, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (bus.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hazard got=%b exp=0", bus.hazard_o);
        end
        @(negedge clk);
        drive_idle();
        bus.rd_sel_i = 4'd2;
        sb.push_back(32'h0000_0004);
        sb.push_back(m_regs[2]);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL b2b_set_wins got=%h exp=%h", bus.pending_o, exp_v);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_value_o !== exp_v) begin
            errors++;
            $display("FAIL b2b_reg2 got=%h exp=%h", bus.rd_value_o, exp_v);
        end
        drive_wb(4'd2, 32'h2222_0002);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_async_reset();
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            drive_idle();
            drive_issue(4'(i), 4'd0, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive_idle();
        sb.push_back(32'h0000_00F0);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL arst_pre got=%h exp=%h", bus.pending_o, exp_v);
        end
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 32'h0;
        end
        bus.rd_sel_i = 4'd5;
        bus.rs_sel_i = 4'd7;
        sb.push_back(32'h0);
        sb.push_back(m_regs[5]);
        sb.push_back(m_regs[7]);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if ({16'h0, bus.pending_o} !== exp_v) begin
            errors++;
            $display("FAIL arst_pending got=%h exp=%h", bus.pending_o, exp_v);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_value_o !== exp_v) begin
            errors++;
            $display("FAIL arst_reg5 got=%h exp=%h", bus.rd_value_o, exp_v);
        end
        exp_v = sb.pop_front();
        checks++;
        if (bus.rs_value_o !== exp_v) begin
            errors++;
            $display("FAIL arst_reg7 got=%h exp=%h", bus.rs_value_o, exp_v);
        end
        drive_issue(4'd4, 4'd9, 1'b1, 1'b1);
        bus.wb_en_i   = 1'b1;
        bus.wb_addr_i = 4'd9;
        bus.wb_data_i = 32'h9999_0009;
        #1;
        checks++;
        if (bus.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_hazard got=%b exp=0", bus.hazard_o);
        end
        checks++;
        if (bus.rs_value_o !== 32'h9999_0009) begin
            errors++;
            $display("FAIL arst_bypass got=%h exp=99990009", bus.rs_value_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        bus.rs_sel_i = 4'd9;
        #1;
        checks++;
        if (bus.rs_value_o !== 32'h0) begin
            errors++;
            $display("FAIL arst_no_write got=%h exp=00000000", bus.rs_value_o);
        end
        checks++;
        if (bus.pending_o !== 16'h0000) begin
            errors++;
            $display("FAIL arst_no_set got=%h exp=0000", bus.pending_o);
        end
        drive_wb(4'd9, 32'h0909_0909);
        @(negedge clk);
        drive_idle();
        bus.rd_sel_i = 4'd9;
        sb.push_back(m_regs[9]);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_value_o !== exp_v) begin
            errors++;
            $display("FAIL post_rst_write got=%h exp=%h", bus.rd_value_o, exp_v);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        test_reset();
        test_write_bypass();
        test_raw_hazard();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
